ex_operand_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the execute-stage ALU.
- Registers decoded operands and ALU control from decode, then forwards results from EX/MEM and MEM/WB onto the ALU's InA/InB.
- Detects load-use hazards, asserts a stall back to fetch/decode, and inserts a bubble.
- Honours a downstream hold and a branch/jump flush.

---
 rtl/ex_operand_stage_pkg.sv | 53 +++++
 rtl/ex_fwd_mux.sv | 30 +++
 rtl/ex_operand_stage.sv | 142 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU control bundle layout, forward-select encoding and opcode
// constants for the ID/EX operand stage.
package ex_operand_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CTL_W  = 10;

  // Bit offsets inside the ALU control bundle {Oper[3:0], instruct[1:0], invA, invB, sign, Cin}
  localparam int CTL_CIN_BIT    = 0;
  localparam int CTL_SIGN_BIT   = 1;
  localparam int CTL_INVB_BIT   = 2;
  localparam int CTL_INVA_BIT   = 3;
  localparam int CTL_INSTR_LSB  = 4;
  localparam int CTL_OPER_LSB   = 6;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Opcode constants shared with opcodes.v
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ALU  = 5'b11011;
  localparam logic [4:0] OP_J    = 5'b00100;

  // Contents of the ID/EX register
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [CTL_W-1:0]  ctl;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              mem_rd;
  } ex_stage_t;

  function automatic logic src_hit(input logic              wr,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src);
    return wr && (rd == src);
  endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB, otherwise the stored register value.
module ex_fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              src_used_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_reg_wr_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_reg_wr_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output fwd_sel_e          sel_o,
  output logic [DATA_W-1:0] operand_o
);

  always_comb begin
    sel_o     = FWD_REG;
    operand_o = src_data_i;
    if (src_used_i && src_hit(exmem_reg_wr_i, exmem_rd_i, src_addr_i)) begin
      sel_o     = FWD_EXMEM;
      operand_o = exmem_result_i;
    end else if (src_used_i && src_hit(memwb_reg_wr_i, memwb_rd_i, src_addr_i)) begin
      sel_o     = FWD_MEMWB;
      operand_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decode outputs, forwards producers onto the ALU inputs,
// and stalls decode on hazards. Define EX_FORWARD_EN to enable operand forwarding.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [CTL_W-1:0]  id_alu_ctl,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              flush,
  input  logic              hold,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_wr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_wr,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_InA,
  output logic [DATA_W-1:0] alu_InB,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_wr,
  output logic              ex_mem_rd,
  output logic              id_stall
);

`ifdef EX_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  ex_stage_t         stage_q, stage_d;
  fwd_sel_e          sel_a, sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              ex_writes, rs_reads, rt_reads;
  logic              load_use, raw, hazard;

  // With forwarding disabled the muxes see used=0 and collapse to the stored data
  ex_fwd_mux u_fwd_a (
    .src_addr_i     (stage_q.rs_addr),
    .src_used_i     (FWD_ON && stage_q.valid && stage_q.rs_used),
    .src_data_i     (stage_q.rs_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_reg_wr_i (exmem_reg_wr),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_reg_wr_i (memwb_reg_wr),
    .memwb_result_i (memwb_result),
    .sel_o          (sel_a),
    .operand_o      (fwd_a)
  );

  ex_fwd_mux u_fwd_b (
    .src_addr_i     (stage_q.rt_addr),
    .src_used_i     (FWD_ON && stage_q.valid && stage_q.rt_used),
    .src_data_i     (stage_q.rt_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_reg_wr_i (exmem_reg_wr),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_reg_wr_i (memwb_reg_wr),
    .memwb_result_i (memwb_result),
    .sel_o          (sel_b),
    .operand_o      (fwd_b)
  );

  assign ex_writes = stage_q.valid & stage_q.reg_wr;
  assign rs_reads  = id_valid & id_rs_used;
  assign rt_reads  = id_valid & id_rt_used;

  assign load_use = ex_writes & stage_q.mem_rd &
                    ((rs_reads & (stage_q.rd == id_rs_addr)) |
                     (rt_reads & (stage_q.rd == id_rt_addr)));

  // Without forwarding any in-flight writer of a decode source must drain first
  assign raw = (rs_reads & (src_hit(ex_writes, stage_q.rd, id_rs_addr) |
                            src_hit(exmem_reg_wr, exmem_rd, id_rs_addr))) |
               (rt_reads & (src_hit(ex_writes, stage_q.rd, id_rt_addr) |
                            src_hit(exmem_reg_wr, exmem_rd, id_rt_addr)));

  assign hazard   = load_use | (!FWD_ON & raw);
  assign id_stall = hazard | hold;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid  = 1'b0;
      stage_d.reg_wr = 1'b0;
      stage_d.mem_rd = 1'b0;
    end else if (hold) begin
      // Capture any producer retiring while frozen so its value survives the hold
      if (sel_a != FWD_REG) stage_d.rs_data = fwd_a;
      if (sel_b != FWD_REG) stage_d.rt_data = fwd_b;
    end else if (hazard) begin
      stage_d.valid  = 1'b0;
      stage_d.reg_wr = 1'b0;
      stage_d.mem_rd = 1'b0;
      stage_d.ctl    = '0;
    end else begin
      stage_d.valid   = id_valid;
      stage_d.rs_addr = id_rs_addr;
      stage_d.rt_addr = id_rt_addr;
      stage_d.rs_used = id_rs_used;
      stage_d.rt_used = id_rt_used;
      stage_d.rs_data = id_rs_data;
      stage_d.rt_data = id_rt_data;
      stage_d.imm     = id_imm;
      stage_d.use_imm = id_use_imm;
      stage_d.ctl     = id_alu_ctl;
      stage_d.rd      = id_rd_addr;
      stage_d.reg_wr  = id_reg_wr;
      stage_d.mem_rd  = id_mem_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign alu_InA    = fwd_a;
  assign alu_InB    = stage_q.use_imm ? stage_q.imm : fwd_b;
  assign alu_ctl    = stage_q.ctl;
  assign ex_valid   = stage_q.valid;
  assign ex_rd_addr = stage_q.rd;
  assign ex_reg_wr  = stage_q.reg_wr;
  assign ex_mem_rd  = stage_q.mem_rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic against a
// behavioural model of the ID/EX stage.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int OUT_W = 2 + REG_AW + 2 + CTL_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              id_valid, id_rs_used, id_rt_used, id_use_imm, id_reg_wr, id_mem_rd;
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [CTL_W-1:0]  id_alu_ctl;
  logic              flush, hold;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic              exmem_reg_wr, memwb_reg_wr;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic [DATA_W-1:0] alu_InA, alu_InB;
  logic [CTL_W-1:0]  alu_ctl;
  logic              ex_valid, ex_reg_wr, ex_mem_rd, id_stall;
  logic [REG_AW-1:0] ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctl(id_alu_ctl),
    .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .flush(flush), .hold(hold),
    .exmem_rd(exmem_rd), .exmem_reg_wr(exmem_reg_wr), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_wr(memwb_reg_wr), .memwb_result(memwb_result),
    .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_ctl(alu_ctl),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .id_stall(id_stall)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs_addr, rt_addr, rd;
    logic              rs_used, rt_used, use_imm, reg_wr, mem_rd;
    logic [DATA_W-1:0] rs_data, rt_data, imm;
    logic [CTL_W-1:0]  ctl;
  } mdl_t;
  mdl_t m;
  logic [OUT_W-1:0] exp_q[$];

  // Value an EX operand sees: youngest matching producer if forwarding, else stored data
  function automatic logic [DATA_W-1:0] m_operand(input logic [REG_AW-1:0] src,
                                                  input logic used,
                                                  input logic [DATA_W-1:0] stored);
    if (FWD && m.valid && used) begin
      if (exmem_reg_wr && exmem_rd == src) return exmem_result;
      if (memwb_reg_wr && memwb_rd == src) return memwb_result;
    end
    return stored;
  endfunction

  function automatic logic decode_reads(input logic [REG_AW-1:0] r);
    return id_valid && ((id_rs_used && id_rs_addr == r) || (id_rt_used && id_rt_addr == r));
  endfunction

  function automatic logic m_hazard();
    logic ex_wr, load_use, raw;
    ex_wr    = m.valid && m.reg_wr;
    load_use = ex_wr && m.mem_rd && decode_reads(m.rd);
    raw      = (ex_wr && decode_reads(m.rd)) || (exmem_reg_wr && decode_reads(exmem_rd));
    return load_use || (!FWD && raw);
  endfunction

  function automatic void m_step();
    logic [DATA_W-1:0] a, b;
    a = m_operand(m.rs_addr, m.rs_used, m.rs_data);
    b = m_operand(m.rt_addr, m.rt_used, m.rt_data);
    if (flush) begin
      m.valid = 1'b0; m.reg_wr = 1'b0; m.mem_rd = 1'b0;
    end else if (hold) begin
      m.rs_data = a; m.rt_data = b;
    end else if (m_hazard()) begin
      m.valid = 1'b0; m.reg_wr = 1'b0; m.mem_rd = 1'b0; m.ctl = '0;
    end else begin
      m.valid = id_valid; m.rs_addr = id_rs_addr; m.rt_addr = id_rt_addr;
      m.rs_used = id_rs_used; m.rt_used = id_rt_used; m.rs_data = id_rs_data;
      m.rt_data = id_rt_data; m.imm = id_imm; m.use_imm = id_use_imm;
      m.ctl = id_alu_ctl; m.rd = id_rd_addr; m.reg_wr = id_reg_wr; m.mem_rd = id_mem_rd;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0; id_alu_ctl = 0;
    id_rd_addr = 0; id_reg_wr = 0; id_mem_rd = 0; flush = 0; hold = 0;
    exmem_rd = 0; exmem_reg_wr = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_wr = 0; memwb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stage();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic set_instr(input logic [REG_AW-1:0] rs, input logic rs_u,
                           input logic [REG_AW-1:0] rt, input logic rt_u,
                           input logic [DATA_W-1:0] rs_d, input logic [DATA_W-1:0] rt_d,
                           input logic [REG_AW-1:0] rd, input logic wr, input logic ld);
    id_valid = 1; id_rs_addr = rs; id_rs_used = rs_u; id_rt_addr = rt; id_rt_used = rt_u;
    id_rs_data = rs_d; id_rt_data = rt_d; id_rd_addr = rd; id_reg_wr = wr; id_mem_rd = ld;
    id_use_imm = 0; id_imm = 0; id_alu_ctl = 10'h2A5;
  endtask

  task automatic drive_random();
    id_valid     = ($urandom_range(0, 7) != 0);
    id_rs_addr   = REG_AW'($urandom_range(0, 3));
    id_rt_addr   = REG_AW'($urandom_range(0, 3));
    id_rd_addr   = REG_AW'($urandom_range(0, 3));
    id_rs_used   = 1'($urandom_range(0, 1));
    id_rt_used   = 1'($urandom_range(0, 1));
    id_use_imm   = ($urandom_range(0, 3) == 0);
    id_reg_wr    = ($urandom_range(0, 3) != 0);
    id_mem_rd    = ($urandom_range(0, 2) == 0);
    id_rs_data   = DATA_W'($urandom);
    id_rt_data   = DATA_W'($urandom);
    id_imm       = DATA_W'($urandom);
    id_alu_ctl   = CTL_W'($urandom);
    flush        = ($urandom_range(0, 9) == 0);
    hold         = ($urandom_range(0, 7) == 0);
    exmem_rd     = REG_AW'($urandom_range(0, 3));
    exmem_reg_wr = 1'($urandom_range(0, 1));
    exmem_result = DATA_W'($urandom);
    memwb_rd     = REG_AW'($urandom_range(0, 3));
    memwb_reg_wr = 1'($urandom_range(0, 1));
    memwb_result = DATA_W'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [OUT_W-1:0] got;
    idle_inputs();
    rst = 1;
    #3;
    got = {id_stall, ex_valid, ex_rd_addr, ex_reg_wr, ex_mem_rd, alu_ctl, alu_InA, alu_InB};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", got); end
    tick();
    rst = 0;
    set_instr(3'd2, 1, 3'd3, 1, 16'hA5A5, 16'h5A5A, 3'd4, 1, 1);
    tick();
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", ex_valid); end
    rst = 1;
    #1;
    got = {1'b0, ex_valid, ex_rd_addr, ex_reg_wr, ex_mem_rd, alu_ctl, alu_InA, alu_InB};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", got); end
    tick();
    rst = 0;
    id_valid = 0;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", ex_valid); end
    id_valid = 1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL first_load: got %b expected 1", ex_valid); end
  endtask

  task automatic test_back_to_back();
    clear_stage();
    set_instr(3'd2, 1, 3'd3, 1, 16'h0102, 16'h0304, 3'd1, 1, 0);
    tick();
    set_instr(3'd1, 1, 3'd3, 1, 16'h5555, 16'h0304, 3'd2, 1, 0);
    #1;
    n_checks++;
    if (id_stall !== !FWD) begin n_fail++; $display("FAIL b2b_stall: got %b expected %b", id_stall, !FWD); end
    if (!FWD) tick();
    tick();
    id_valid = 0;
    exmem_rd = 3'd1; exmem_reg_wr = 1; exmem_result = 16'h1234;
    memwb_rd = 3'd1; memwb_reg_wr = 1; memwb_result = 16'hBEEF;
    #1;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd_addr !== 3'd2) begin
      n_fail++; $display("FAIL b2b_dest: got valid=%b rd=%0d expected valid=1 rd=2", ex_valid, ex_rd_addr);
    end
    n_checks++;
    if (alu_InA !== (FWD ? 16'h1234 : 16'h5555)) begin
      n_fail++; $display("FAIL b2b_inA: got %h expected %h", alu_InA, FWD ? 16'h1234 : 16'h5555);
    end
    n_checks++;
    if (alu_InB !== 16'h0304) begin n_fail++; $display("FAIL b2b_inB: got %h expected 0304", alu_InB); end
  endtask

  task automatic test_load_use();
    clear_stage();
    set_instr(3'd2, 1, 3'd0, 0, 16'h0010, 16'h0000, 3'd4, 1, 1);
    tick();
    set_instr(3'd6, 1, 3'd4, 1, 16'h0606, 16'h7777, 3'd5, 1, 0);
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", id_stall); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0 || alu_ctl !== '0) begin
      n_fail++; $display("FAIL lu_bubble: got valid=%b mem_rd=%b ctl=%h expected 0/0/0", ex_valid, ex_mem_rd, alu_ctl);
    end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b expected 0", id_stall); end
    tick();
    id_valid = 0;
    memwb_rd = 3'd4; memwb_reg_wr = 1; memwb_result = 16'h0C0C;
    #1;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd_addr !== 3'd5) begin
      n_fail++; $display("FAIL lu_dependent: got valid=%b rd=%0d expected valid=1 rd=5", ex_valid, ex_rd_addr);
    end
    n_checks++;
    if (alu_InB !== (FWD ? 16'h0C0C : 16'h7777)) begin
      n_fail++; $display("FAIL lu_inB: got %h expected %h", alu_InB, FWD ? 16'h0C0C : 16'h7777);
    end
  endtask

  task automatic test_immediate();
    clear_stage();
    set_instr(3'd0, 0, 3'd2, 1, 16'h0000, 16'h2222, 3'd6, 1, 0);
    id_use_imm = 1; id_imm = 16'hFFF0;
    tick();
    id_valid = 0;
    exmem_rd = 3'd2; exmem_reg_wr = 1; exmem_result = 16'h1111;
    #1;
    n_checks++;
    if (alu_InB !== 16'hFFF0) begin n_fail++; $display("FAIL imm_inB: got %h expected fff0", alu_InB); end
  endtask

  task automatic test_hold_retire();
    clear_stage();
    set_instr(3'd5, 1, 3'd0, 0, 16'h0001, 16'h0000, 3'd7, 1, 0);
    tick();
    id_valid = 0; hold = 1;
    memwb_rd = 3'd5; memwb_reg_wr = 1; memwb_result = 16'h00AA;
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall: got %b expected 1", id_stall); end
    tick();
    memwb_reg_wr = 0; memwb_result = 16'h0000;
    tick();
    hold = 0;
    #1;
    n_checks++;
    if (alu_InA !== (FWD ? 16'h00AA : 16'h0001) || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_retire: got inA=%h valid=%b expected inA=%h valid=1",
                         alu_InA, ex_valid, FWD ? 16'h00AA : 16'h0001);
    end
  endtask

  task automatic test_flush_hold();
    clear_stage();
    set_instr(3'd1, 1, 3'd2, 1, 16'h0011, 16'h0022, 3'd3, 1, 0);
    tick();
    set_instr(3'd3, 1, 3'd0, 0, 16'h0033, 16'h0000, 3'd4, 1, 0);
    #1;
    n_checks++;
    if (id_stall !== !FWD) begin n_fail++; $display("FAIL raw_ex_stall: got %b expected %b", id_stall, !FWD); end
    flush = 1; hold = 1;
    tick();
    flush = 0; hold = 0; id_valid = 0;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_reg_wr !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: got valid=%b reg_wr=%b expected 0/0", ex_valid, ex_reg_wr);
    end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] got, exp;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      drive_random();
      #1;
      exp_q.push_back({m_hazard() || hold, m.valid, m.rd, m.reg_wr, m.mem_rd, m.ctl,
                       m_operand(m.rs_addr, m.rs_used, m.rs_data),
                       m.use_imm ? m.imm : m_operand(m.rt_addr, m.rt_used, m.rt_data)});
      got = {id_stall, ex_valid, ex_rd_addr, ex_reg_wr, ex_mem_rd, alu_ctl, alu_InA, alu_InB};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
      @(posedge clk);
      m_step();
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_immediate();
    test_hold_retire();
    test_flush_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
